// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage (master) and memory (slave).
// The request is held until the completion strobe; the address is the fetch PC.
interface fetch_unit_if;
    logic [31:0] inst_addr;
    logic        inst_req;
    logic [31:0] inst;
    logic        inst_ready;

    modport master (
        output inst_addr,
        output inst_req,
        input  inst,
        input  inst_ready
    );

    modport slave (
        input  inst_addr,
        input  inst_req,
        output inst,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, instruction register with decoded fields,
// next-PC selection from the control unit's decisions, and halt on syscall/misalignment.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [5:0]  SYSCALL_FUNC = 6'h0C
) (
    input  logic              clk,
    input  logic              rst_b,
    fetch_unit_if.master      imem,
    input  logic              advance,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic              branch,
    input  logic              branch_take,
    input  logic [31:0]       rs_data,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [15:0]       imm,
    output logic [31:0]       pc_plus4,
    output logic              ir_valid,
    output logic              halted,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic        inst_req_reg, inst_req_next;
    logic        ir_valid_reg, ir_valid_next;
    logic        halted_reg, halted_next;
    logic        addr_err_reg, addr_err_next;

    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] next_pc;
    logic        is_syscall;

    assign pc_plus4      = pc_reg + 32'd4;
    assign jump_target   = {pc_plus4[31:28], ir_reg[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};
    assign is_syscall    = (ir_reg[31:26] == 6'h00) && (ir_reg[5:0] == SYSCALL_FUNC);

    // Register-indirect jumps override direct jumps, which override branches.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = rs_data;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch && branch_take) begin
            next_pc = branch_target;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        inst_req_next = inst_req_reg;
        ir_valid_next = ir_valid_reg;
        halted_next   = halted_reg;
        addr_err_next = addr_err_reg;
        case (state_reg)
            IDLE: begin
                state_next    = FETCH;
                inst_req_next = 1'b1;
            end
            FETCH: begin
                if (imem.inst_ready) begin
                    ir_next       = imem.inst;
                    state_next    = HOLD;
                    inst_req_next = 1'b0;
                    ir_valid_next = 1'b1;
                end
            end
            HOLD: begin
                if (advance) begin
                    if (is_syscall) begin
                        state_next  = HALT;
                        halted_next = 1'b1;
                    end else if (next_pc[1:0] != 2'b00) begin
                        // PC is left pointing at the faulting instruction.
                        state_next    = HALT;
                        halted_next   = 1'b1;
                        addr_err_next = 1'b1;
                    end else begin
                        pc_next       = next_pc;
                        state_next    = FETCH;
                        ir_valid_next = 1'b0;
                        inst_req_next = 1'b1;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            ir_reg       <= 32'h0000_0000;
            inst_req_reg <= 1'b0;
            ir_valid_reg <= 1'b0;
            halted_reg   <= 1'b0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            inst_req_reg <= inst_req_next;
            ir_valid_reg <= ir_valid_next;
            halted_reg   <= halted_next;
            addr_err_reg <= addr_err_next;
        end
    end

    assign imem.inst_addr = pc_reg;
    assign imem.inst_req  = inst_req_reg;
    assign ir_valid       = ir_valid_reg;
    assign halted         = halted_reg;
    assign addr_err       = addr_err_reg;

    assign opcode = ir_reg[31:26];
    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign rd     = ir_reg[15:11];
    assign shamt  = ir_reg[10:6];
    assign func   = ir_reg[5:0];
    assign imm    = ir_reg[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch addresses and halts,
// a monitor compares them whenever the DUT accepts a fetch, loads ir, or halts.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int MODE_FETCH = 0;
    localparam int MODE_HALT  = 1;
    localparam int MODE_NONE  = 2;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        advance = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        branch = 1'b0;
    logic        branch_take = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] pc_plus4;
    logic        ir_valid, halted, addr_err;

    logic        mem_ready_en = 1'b1;
    logic        force_ready = 1'b0;
    logic [31:0] syscall_addr = 32'hDEAD_BEE0;

    always #5 clk = ~clk;

    fetch_unit_if imem();

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .SYSCALL_FUNC(6'h0C)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .imem(imem),
        .advance(advance),
        .jump(jump),
        .jump_reg(jump_reg),
        .branch(branch),
        .branch_take(branch_take),
        .rs_data(rs_data),
        .opcode(opcode),
        .func(func),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .shamt(shamt),
        .imm(imm),
        .pc_plus4(pc_plus4),
        .ir_valid(ir_valid),
        .halted(halted),
        .addr_err(addr_err)
    );

    // Program image: a beq at 0x100, a j at 0x1000_0000, optional syscall, else R-type adds.
    function automatic logic [31:0] word_at(input logic [31:0] a, input logic [31:0] sc);
        if (a == sc) return 32'h0000_000C;
        case (a)
            32'h0000_0100: return 32'h1000_FFFE;
            32'h1000_0000: return 32'h0800_0010;
            default:       return {6'h00, a[6:2], 5'd2, 5'd3, 5'd0, 6'h20};
        endcase
    endfunction

    assign imem.inst       = word_at(imem.inst_addr, syscall_addr);
    assign imem.inst_ready = mem_ready_en & (imem.inst_req | force_ready);

    typedef struct {
        logic [31:0] addr;
        int          gap;
    } fetch_exp_t;

    typedef struct {
        logic        err;
        logic [31:0] addr;
    } halt_exp_t;

    fetch_exp_t fetch_q[$];
    halt_exp_t  halt_q[$];
    int         total = 0;
    int         passed = 0;
    longint     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end else begin
            passed++;
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        total++;
        $display("FAIL %s: got 0x%0h with nothing expected at t=%0t", name, act, $time);
    endtask

    // Monitor
    logic        prev_valid = 1'b0;
    logic        prev_halted = 1'b0;
    logic [31:0] pend_word = 32'h0;
    int          pend_gap = 0;
    longint      last_rise = 0;

    initial begin : monitor
        fetch_exp_t fe;
        halt_exp_t  he;
        forever begin
            @(negedge clk);
            if (imem.inst_req && imem.inst_ready) begin
                if (fetch_q.size() == 0) begin
                    note_fail("unexpected_fetch", {32'h0, imem.inst_addr});
                end else begin
                    fe = fetch_q.pop_front();
                    check("fetch_addr", {32'h0, imem.inst_addr}, {32'h0, fe.addr});
                    pend_word = word_at(fe.addr, syscall_addr);
                    pend_gap  = fe.gap;
                end
            end
            if (ir_valid && !prev_valid) begin
                check("ir_fields", {32'h0, opcode, rs, rt, rd, shamt, func}, {32'h0, pend_word});
                check("ir_imm", {48'h0, imm}, {48'h0, pend_word[15:0]});
                if (pend_gap != 0) check("issue_gap", cyc - last_rise, 64'(pend_gap));
                last_rise = cyc;
            end
            if (halted && !prev_halted) begin
                if (halt_q.size() == 0) begin
                    note_fail("unexpected_halt", {32'h0, imem.inst_addr});
                end else begin
                    he = halt_q.pop_front();
                    check("halt_addr_err", {63'h0, addr_err}, {63'h0, he.err});
                    check("halt_inst_addr", {32'h0, imem.inst_addr}, {32'h0, he.addr});
                    check("halt_inst_req", {63'h0, imem.inst_req}, 64'h0);
                end
            end
            prev_valid  = ir_valid;
            prev_halted = halted;
        end
    end

    task automatic chk_reset();
        check("rst_inst_req", {63'h0, imem.inst_req}, 64'h0);
        check("rst_ir_valid", {63'h0, ir_valid}, 64'h0);
        check("rst_halted", {63'h0, halted}, 64'h0);
        check("rst_addr_err", {63'h0, addr_err}, 64'h0);
        check("rst_inst_addr", {32'h0, imem.inst_addr}, {32'h0, RESET_PC});
        check("rst_pc_plus4", {32'h0, pc_plus4}, {32'h0, RESET_PC + 32'd4});
        check("rst_ir_zero", {32'h0, opcode, rs, rt, rd, shamt, func}, 64'h0);
    endtask

    // Assert reset mid-cycle so the check lands before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #2 rst_b = 1'b0;
        #1 chk_reset();
        fetch_q.delete();
        halt_q.delete();
        mem_ready_en = 1'b1;
        force_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        fetch_q.push_back('{RESET_PC, 0});
        rst_b = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ir_valid && !halted) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) note_fail("ir_valid_timeout", {32'h0, imem.inst_addr});
    endtask

    task automatic step(input logic j, input logic jr, input logic br, input logic bt,
                        input logic [31:0] rsd, input logic [31:0] exp_addr,
                        input int mode, input logic err);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            if (mode == MODE_FETCH) fetch_q.push_back('{exp_addr, 2});
            else if (mode == MODE_HALT) halt_q.push_back('{err, exp_addr});
            jump = j; jump_reg = jr; branch = br; branch_take = bt; rs_data = rsd;
            advance = 1'b1;
            @(negedge clk);
            advance = 1'b0; jump = 1'b0; jump_reg = 1'b0; branch = 1'b0; branch_take = 1'b0;
        end
    endtask

    task automatic wait_halted();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        check("halt_seen", {63'h0, halted}, 64'h1);
    endtask

    // HALT must ignore advance and stray ready strobes.
    task automatic post_halt(input logic [31:0] exp_addr, input logic exp_err);
        advance = 1'b1; jump_reg = 1'b1; rs_data = 32'h40; force_ready = 1'b1;
        repeat (3) @(negedge clk);
        advance = 1'b0; jump_reg = 1'b0; force_ready = 1'b0;
        @(negedge clk);
        check("hold_halted", {63'h0, halted}, 64'h1);
        check("hold_inst_req", {63'h0, imem.inst_req}, 64'h0);
        check("hold_inst_addr", {32'h0, imem.inst_addr}, {32'h0, exp_addr});
        check("hold_addr_err", {63'h0, addr_err}, {63'h0, exp_err});
    endtask

    initial begin : stimulus
        bit ok;
        // Sequential fetch, branches, jumps, wrap, then misaligned jump-register.
        do_reset();
        step(0, 0, 0, 0, 32'h0,         32'h0000_0004, MODE_FETCH, 0);
        step(0, 0, 0, 0, 32'h0,         32'h0000_0008, MODE_FETCH, 0);
        step(0, 1, 0, 0, 32'h0000_0100, 32'h0000_0100, MODE_FETCH, 0);
        step(0, 0, 1, 1, 32'h0,         32'h0000_00FC, MODE_FETCH, 0);
        step(0, 1, 0, 0, 32'h0000_0100, 32'h0000_0100, MODE_FETCH, 0);
        step(0, 0, 1, 0, 32'h0,         32'h0000_0104, MODE_FETCH, 0);
        step(0, 1, 0, 0, 32'h1000_0000, 32'h1000_0000, MODE_FETCH, 0);
        step(1, 0, 0, 0, 32'h0,         32'h1000_0040, MODE_FETCH, 0);
        step(1, 1, 0, 0, 32'h0000_2000, 32'h0000_2000, MODE_FETCH, 0);
        step(0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, MODE_FETCH, 0);
        step(0, 0, 0, 0, 32'h0,         32'h0000_0000, MODE_FETCH, 0);
        step(0, 0, 0, 0, 32'h0,         32'h0000_0004, MODE_FETCH, 0);
        step(0, 1, 0, 0, 32'h0000_2002, 32'h0000_0004, MODE_HALT,  1);
        wait_halted();
        post_halt(32'h0000_0004, 1'b1);

        // Syscall at 0x8 wins over a simultaneous misaligned jump-register.
        syscall_addr = 32'h0000_0008;
        do_reset();
        step(0, 0, 0, 0, 32'h0,         32'h0000_0004, MODE_FETCH, 0);
        step(0, 0, 0, 0, 32'h0,         32'h0000_0008, MODE_FETCH, 0);
        step(0, 1, 0, 0, 32'h0000_2002, 32'h0000_0008, MODE_HALT,  0);
        wait_halted();
        post_halt(32'h0000_0008, 1'b0);
        syscall_addr = 32'hDEAD_BEE0;

        // Reset while a fetch is stalled, then while holding an instruction.
        do_reset();
        wait_valid(ok);
        mem_ready_en = 1'b0;
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        repeat (2) @(negedge clk);
        check("stall_inst_req", {63'h0, imem.inst_req}, 64'h1);
        check("stall_inst_addr", {32'h0, imem.inst_addr}, 64'h4);
        check("stall_ir_valid", {63'h0, ir_valid}, 64'h0);
        do_reset();
        wait_valid(ok);
        do_reset();
        step(0, 0, 0, 0, 32'h0, 32'h0000_0004, MODE_FETCH, 0);
        wait_valid(ok);
        repeat (3) @(negedge clk);
        check("fetch_q_drained", 64'(fetch_q.size()), 64'h0);
        check("halt_q_drained", 64'(halt_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage with a program counter. It holds the current instruction register and drives its decoded fields (opcode, func, register numbers, immediate) into the control unit. It consumes that unit's Jump/JumpReg/Branch decisions, plus the ALU branch condition, to compute the next PC. It runs a request/ready handshake with instruction memory and halts the core on syscall or on a misaligned target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset; must be word-aligned.
- SYSCALL_FUNC, 6'h0C, func code that, with opcode 6'h00, marks a syscall.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- inst_addr  out  32  fetch address; equals the PC register.
- inst_req  out  1  registered request to instruction memory.
- inst  in  32  instruction word; sampled only when inst_req && inst_ready.
- inst_ready  in  1  memory completion strobe.
- advance  in  1  execute/writeback has finished the held instruction; load next PC.
- jump, jump_reg, branch  in  1 each  from the control unit, for the held instruction.
- branch_take  in  1  ALU condition result; meaningful only when branch=1.
- rs_data  in  32  register-file rs value, used as the jump-register target.
- opcode, func  out  6 each  ir[31:26], ir[5:0].
- rs, rt, rd, shamt  out  5 each  ir[25:21], ir[20:16], ir[15:11], ir[10:6].
- imm  out  16  ir[15:0].
- pc_plus4  out  32  PC+4, the link value for jal (no delay slot).
- ir_valid  out  1  the held instruction is valid and the decoded fields are stable.
- halted  out  1  the core is stopped.
- addr_err  out  1  the halt was caused by a misaligned next PC.

## Operation
- States: IDLE, FETCH, HOLD, HALT. Reset state is IDLE.
- IDLE -> FETCH on the first edge after reset release. FETCH asserts inst_req.
- FETCH: if inst_ready, at the edge: ir <= inst, go to HOLD, inst_req <= 0, ir_valid <= 1. Otherwise stay in FETCH with inst_addr stable.
- HOLD: fields are driven from ir. On advance:
  - If ir is a syscall (opcode 0, func SYSCALL_FUNC): go to HALT, halted <= 1. PC is unchanged.
  - Else if next_pc[1:0] != 0: go to HALT, halted <= 1, addr_err <= 1. PC is unchanged.
  - Else: PC <= next_pc, go to FETCH, ir_valid <= 0, inst_req <= 1.
- next_pc priority:
  - jump_reg: rs_data.
  - else jump: {pc_plus4[31:28], ir[25:0], 2'b00}.
  - else branch && branch_take: pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}).
  - else pc_plus4.
- Arithmetic is 32-bit modulo: PC 32'hFFFF_FFFC + 4 wraps to 0. A branch offset wraps the same way. No error is raised for wrap.
- HALT is terminal until reset. inst_req = 0 and advance is ignored.
- inst_ready outside FETCH is ignored. advance outside HOLD is ignored.
- ir is not cleared on leaving HOLD. Fields stay at the last value while ir_valid = 0.

## Timing
- Reset values (asynchronous, while rst_b = 0):
  - state = IDLE, PC = RESET_PC, ir = 0 (decodes as sll $0, a no-op).
  - inst_req = 0, ir_valid = 0, halted = 0, addr_err = 0.
- inst_req rises on the first clk edge after rst_b deasserts.
- Fetch latency: ir_valid rises on the edge that samples inst_ready = 1. The minimum is 1 cycle after inst_req rises.
- Throughput: at best 2 cycles per instruction (FETCH 1 cycle, HOLD 1 cycle with advance = 1).
- After advance, inst_addr shows the new PC and inst_req = 1 in the next cycle.
- inst_req stays high until the ready edge. The memory must not change inst_addr semantics mid-request.
- Reset mid-fetch abandons the request immediately. The memory must tolerate a dropped request.
- The control inputs, branch_take and rs_data are sampled only on the edge where HOLD && advance holds.
- pc_plus4 is combinational from PC. All other outputs are registered, except the field slices of ir.

## Test plan
- Sequential fetch: RESET_PC = 0, memory ready next cycle, 3 plain R-type words, advance held high. Required: inst_addr = 0, 4, 8; ir_valid pulses once per word; 2 cycles per instruction.
- Branch taken: PC = 0x100, branch = 1, branch_take = 1, imm = 16'hFFFE. Required: next inst_addr = 0x0FC. Repeat with branch_take = 0: required inst_addr = 0x104.
- Jump and jump-register:
  - PC = 0x1000_0000, jump = 1, ir[25:0] = 26'h10. Required: 0x1000_0040.
  - jump = 1, jump_reg = 1, rs_data = 0x2000. Required: 0x2000 (jump_reg wins).
- Syscall: ir = 32'h0000_000C, advance = 1. Required: halted = 1, addr_err = 0, inst_req = 0 forever; later advance and inst_ready pulses change nothing.
- Misaligned and wrap:
  - jump_reg with rs_data = 0x2002. Required: halted = 1, addr_err = 1, inst_addr unchanged.
  - PC = 32'hFFFF_FFFC, plain advance. Required: inst_addr = 0, no error.
- Reset mid-operation: assert rst_b = 0 while in FETCH with inst_ready stalled, then while in HOLD. Required: outputs at their reset values immediately, without waiting for a clock edge; refetch from RESET_PC after release.
